// File: rtl/wb_write_scheduler_pkg.sv
// Shared types and constants for the writeback scheduler: source count,
// round-robin pointer type, request record and the modulo-6 pointer step.
package wb_write_scheduler_pkg;

  localparam int WB_NUM_SRC = 6;
  localparam int WB_PTR_W   = 3;
  localparam int WB_ADDR_W  = 6;
  localparam int WB_DATA_W  = 64;

  typedef logic [WB_PTR_W-1:0] wb_ptr_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] address;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // 3-bit pointer with an explicit wrap at the source count, so 6 and 7 never appear
  function automatic wb_ptr_t wb_ptr_inc(input wb_ptr_t p);
    return (p == wb_ptr_t'(WB_NUM_SRC - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/wb_write_scheduler_if.sv
// Writeback-source handshake bus and the two registered regfile write ports.
interface wb_write_scheduler_if #(
  parameter int REG_ADDR_WIDTH = 6,
  parameter int REG_DATA_WIDTH = 64,
  parameter int NUM_SRC        = 6
);
  logic [NUM_SRC-1:0]                wr_valid;
  logic [NUM_SRC-1:0]                wr_ready;
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] wr_address;
  logic [NUM_SRC*REG_DATA_WIDTH-1:0] wr_data;

  logic                      wr_first_valid;
  logic [REG_ADDR_WIDTH-1:0] wr_first_address;
  logic [REG_DATA_WIDTH-1:0] wr_first_data;
  logic                      wr_second_valid;
  logic [REG_ADDR_WIDTH-1:0] wr_second_address;
  logic [REG_DATA_WIDTH-1:0] wr_second_data;

  modport master (
    output wr_valid, wr_address, wr_data,
    input  wr_ready,
    input  wr_first_valid, wr_first_address, wr_first_data,
    input  wr_second_valid, wr_second_address, wr_second_data
  );

  modport slave (
    input  wr_valid, wr_address, wr_data,
    output wr_ready,
    output wr_first_valid, wr_first_address, wr_first_data,
    output wr_second_valid, wr_second_address, wr_second_data
  );
endinterface

// File: rtl/wb_write_scheduler_rr_pick2.sv
// Combinational round-robin picker: starting at ptr, finds the first two
// occupied slots and returns them one-hot plus their indices.
module wb_rr_pick2
  import wb_write_scheduler_pkg::*;
(
  input  logic [WB_NUM_SRC-1:0] occ,
  input  wb_ptr_t               ptr,
  output logic [WB_NUM_SRC-1:0] grant_a,
  output logic [WB_NUM_SRC-1:0] grant_b,
  output logic                  found_a,
  output logic                  found_b,
  output wb_ptr_t               idx_a,
  output wb_ptr_t               idx_b
);

  wb_ptr_t cur;

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    cur     = ptr;
    for (int k = 0; k < WB_NUM_SRC; k++) begin
      if (occ[cur]) begin
        if (!found_a) begin
          found_a      = 1'b1;
          grant_a[cur] = 1'b1;
          idx_a        = cur;
        end else if (!found_b) begin
          found_b      = 1'b1;
          grant_b[cur] = 1'b1;
          idx_b        = cur;
        end
      end
      cur = wb_ptr_inc(cur);
    end
  end

endmodule

// File: rtl/wb_write_scheduler.sv
// Six 1-entry writeback buffers arbitrated round-robin onto two registered
// regfile write ports; same-address pairs are serialised to keep write order.
module wb_write_scheduler
  import wb_write_scheduler_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = WB_ADDR_W,
  parameter int REG_DATA_WIDTH = WB_DATA_W,
  parameter int NUM_SRC        = WB_NUM_SRC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  wb_write_scheduler_if.slave bus
);

  logic [NUM_SRC-1:0]        buf_valid;
  logic [REG_ADDR_WIDTH-1:0] buf_addr [NUM_SRC];
  logic [REG_DATA_WIDTH-1:0] buf_data [NUM_SRC];
  wb_ptr_t                   rr_ptr;
  wb_req_t                   first_q;
  wb_req_t                   second_q;

  logic [NUM_SRC-1:0] take;
  logic [NUM_SRC-1:0] grant_a;
  logic [NUM_SRC-1:0] grant_b;
  logic [NUM_SRC-1:0] grant_mask;
  logic               found_a;
  logic               found_b;
  logic               take_b;
  wb_ptr_t            idx_a;
  wb_ptr_t            idx_b;

  assign bus.wr_ready = ~buf_valid;
  assign take         = bus.wr_valid & ~buf_valid;

  wb_rr_pick2 u_pick (
    .occ     (buf_valid),
    .ptr     (rr_ptr),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .found_a (found_a),
    .found_b (found_b),
    .idx_a   (idx_a),
    .idx_b   (idx_b)
  );

  // B shares A's register index: hold B back so the regfile sees A's write first
  assign take_b     = found_b && (buf_addr[idx_a] != buf_addr[idx_b]);
  assign grant_mask = grant_a | (take_b ? grant_b : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      first_q   <= '0;
      second_q  <= '0;
    end else if (flush) begin
      buf_valid <= '0;
      first_q   <= '0;
      second_q  <= '0;
    end else begin
      buf_valid <= (buf_valid & ~grant_mask) | take;
      first_q   <= found_a ? '{valid: 1'b1, address: buf_addr[idx_a], data: buf_data[idx_a]} : '0;
      second_q  <= take_b  ? '{valid: 1'b1, address: buf_addr[idx_b], data: buf_data[idx_b]} : '0;
      if (take_b)
        rr_ptr <= wb_ptr_inc(idx_b);
      else if (found_a)
        rr_ptr <= wb_ptr_inc(idx_a);
    end
  end

  // Payload needs no reset; an invalid buffer's contents are never granted
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take[i]) begin
        buf_addr[i] <= bus.wr_address[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        buf_data[i] <= bus.wr_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
    end
  end

  assign bus.wr_first_valid    = first_q.valid;
  assign bus.wr_first_address  = first_q.address;
  assign bus.wr_first_data     = first_q.data;
  assign bus.wr_second_valid   = second_q.valid;
  assign bus.wr_second_address = second_q.address;
  assign bus.wr_second_data    = second_q.data;

endmodule
